voice_alloc: RTL and testbench

//  Polyphonic voice allocator between the MIDI decoder and the oscillator/envelope voices.

---
 rtl/voice_alloc.sv | 163 ++++++++++++++++
 tb/tb_voice_alloc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// ---------------------------------------------------------------------------
// voice_alloc
//   Polyphonic voice allocator. Decoded note-on / note-off events are mapped
//   onto VOICES voices. A note-on goes to the lowest voice already holding
//   that note (retrigger), else to the lowest free voice, else the least-
//   recently-assigned voice is stolen. All outputs are registered, so each
//   response appears one clock after the event is sampled.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   ce           event enable; inputs are sampled only when ce=1
//   note_on      note-on flag
//   note_off     note-off flag (wins over note_on; covers vel-0 note-on)
//   note_num     7-bit note number of the event
//   note_vel     7-bit velocity of the event
//   voice_gate   per-voice gate (1 = key held)
//   voice_note   packed per-voice note, voice v at [7v+6:7v]
//   voice_vel    packed per-voice velocity, voice v at [7v+6:7v]
//   voice_trig   one-clock pulse on the voice that was (re)assigned
//   steal        one-clock pulse when a gated voice was stolen
//   active_cnt   number of gated voices
// ---------------------------------------------------------------------------
module voice_alloc #(
   parameter int VOICES = 4,
   parameter int VIDX_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  note_on,
   input  logic                  note_off,
   input  logic [6:0]            note_num,
   input  logic [6:0]            note_vel,
   output logic [VOICES-1:0]     voice_gate,
   output logic [7*VOICES-1:0]   voice_note,
   output logic [7*VOICES-1:0]   voice_vel,
   output logic [VOICES-1:0]     voice_trig,
   output logic                  steal,
   output logic [VIDX_W:0]       active_cnt
);

   typedef logic [VIDX_W-1:0] vidx_t;

   // Per-voice state. age is an LRU rank: 0 = most recently assigned,
   // VOICES-1 = steal candidate. The ranks always form a permutation.
   logic [6:0] note_q [VOICES];
   logic [6:0] vel_q  [VOICES];
   vidx_t      age_q  [VOICES];

   logic [6:0]        note_nxt [VOICES];
   logic [6:0]        vel_nxt  [VOICES];
   vidx_t             age_nxt  [VOICES];
   logic [VOICES-1:0] gate_nxt;
   logic [VOICES-1:0] trig_nxt;
   logic              steal_nxt;
   logic [VIDX_W:0]   cnt_nxt;

   logic              ev_on;
   logic              ev_off;
   logic [VOICES-1:0] match;
   vidx_t             tgt;
   logic              found;
   logic              do_steal;

   // note_off has priority so a velocity-0 note-on releases the note.
   assign ev_off = ce & note_off;
   assign ev_on  = ce & note_on & ~note_off;

   for (genvar g = 0; g < VOICES; g++) begin : g_pack
      assign voice_note[7*g +: 7] = note_q[g];
      assign voice_vel [7*g +: 7] = vel_q[g];
   end

   // Target search: matching gated voice, then lowest free, then oldest.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      match    = '0;
      tgt      = '0;
      found    = 1'b0;
      do_steal = 1'b0;
      for (int v = 0; v < VOICES; v++)
         match[v] = voice_gate[v] && (note_q[v] == note_num);
      for (int v = 0; v < VOICES; v++) begin
         if (!found && match[v]) begin
            tgt   = vidx_t'(v);
            found = 1'b1;
         end
      end
      for (int v = 0; v < VOICES; v++) begin
         if (!found && !voice_gate[v]) begin
            tgt   = vidx_t'(v);
            found = 1'b1;
         end
      end
      if (!found) begin
         do_steal = 1'b1;
         for (int v = 0; v < VOICES; v++)
            if (age_q[v] == vidx_t'(VOICES-1))
               tgt = vidx_t'(v);
      end
   end

   // Next-state computation for all voices.
   always_comb begin
      gate_nxt  = voice_gate;
      note_nxt  = note_q;
      vel_nxt   = vel_q;
      age_nxt   = age_q;
      trig_nxt  = '0;
      steal_nxt = 1'b0;
      cnt_nxt   = '0;
      if (ev_off) begin
         // Note and velocity stay put so the envelope can release on them.
         for (int v = 0; v < VOICES; v++)
            if (match[v])
               gate_nxt[v] = 1'b0;
      end else if (ev_on) begin
         gate_nxt[tgt] = 1'b1;
         note_nxt[tgt] = note_num;
         vel_nxt[tgt]  = note_vel;
         trig_nxt[tgt] = 1'b1;
         steal_nxt     = do_steal;
         // Move the target to rank 0; only voices younger than it shift
         // down, so the ranks remain a permutation.
         for (int v = 0; v < VOICES; v++) begin
            if (vidx_t'(v) == tgt)
               age_nxt[v] = '0;
            else if (age_q[v] < age_q[tgt])
               age_nxt[v] = age_q[v] + vidx_t'(1);
         end
      end
      for (int v = 0; v < VOICES; v++)
         cnt_nxt = cnt_nxt + (VIDX_W+1)'(gate_nxt[v]);
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         voice_gate <= '0;
         voice_trig <= '0;
         steal      <= 1'b0;
         active_cnt <= '0;
         // NOTE: the per-voice note/velocity arrays are reset too, because
         // they are visible outputs with a defined post-reset value.
         for (int v = 0; v < VOICES; v++) begin
            note_q[v] <= '0;
            vel_q[v]  <= '0;
            age_q[v]  <= vidx_t'(v);
         end
      end else begin
         voice_gate <= gate_nxt;
         voice_trig <= trig_nxt;
         steal      <= steal_nxt;
         active_cnt <= cnt_nxt;
         note_q     <= note_nxt;
         vel_q      <= vel_nxt;
         age_q      <= age_nxt;
      end
   end

endmodule

// File: tb/tb_voice_alloc.sv
// ---------------------------------------------------------------------------
// tb_voice_alloc
//   Self-checking bench for voice_alloc (VOICES=4). A directed table of
//   events with constant expectations, hand sequences for ce gating and
//   reset colliding with an event, then random events compared every cycle
//   against a reference model that tracks recency with an ordered list.
// ---------------------------------------------------------------------------
module tb_voice_alloc;

   localparam int VOICES = 4;
   localparam int VIDX_W = 2;

   logic                clk = 1'b0;
   logic                rst, ce, note_on, note_off;
   logic [6:0]          note_num, note_vel;
   logic [VOICES-1:0]   voice_gate, voice_trig;
   logic [7*VOICES-1:0] voice_note, voice_vel;
   logic                steal;
   logic [VIDX_W:0]     active_cnt;

   voice_alloc #(.VOICES(VOICES), .VIDX_W(VIDX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .note_on    (note_on),
      .note_off   (note_off),
      .note_num   (note_num),
      .note_vel   (note_vel),
      .voice_gate (voice_gate),
      .voice_note (voice_note),
      .voice_vel  (voice_vel),
      .voice_trig (voice_trig),
      .steal      (steal),
      .active_cnt (active_cnt)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [VOICES-1:0] m_gate, m_trig;
   logic              m_steal;
   logic [6:0]        m_note [VOICES];
   logic [6:0]        m_vel  [VOICES];
   int                lru [$];   // front = most recently assigned

   task automatic model_step(input logic r, input logic c, input logic on,
                             input logic off, input logic [6:0] num,
                             input logic [6:0] vel);
      int t;
      m_trig  = '0;
      m_steal = 1'b0;
      if (r) begin
         m_gate = '0;
         lru    = {};
         for (int v = 0; v < VOICES; v++) begin
            m_note[v] = '0;
            m_vel[v]  = '0;
            lru.push_back(v);
         end
         return;
      end
      if (!c) return;
      if (off) begin
         for (int v = 0; v < VOICES; v++)
            if (m_gate[v] && m_note[v] == num) m_gate[v] = 1'b0;
      end else if (on) begin
         t = -1;
         for (int v = 0; v < VOICES; v++)
            if (t < 0 && m_gate[v] && m_note[v] == num) t = v;
         for (int v = 0; v < VOICES; v++)
            if (t < 0 && !m_gate[v]) t = v;
         if (t < 0) begin
            t       = lru[$];
            m_steal = 1'b1;
         end
         m_gate[t] = 1'b1;
         m_note[t] = num;
         m_vel[t]  = vel;
         m_trig[t] = 1'b1;
         for (int i = 0; i < lru.size(); i++)
            if (lru[i] == t) begin
               lru.delete(i);
               break;
            end
         lru.push_front(t);
      end
   endtask

   task automatic compare_model();
      logic [7*VOICES-1:0] en, ev;
      for (int v = 0; v < VOICES; v++) begin
         en[7*v +: 7] = m_note[v];
         ev[7*v +: 7] = m_vel[v];
      end
      check("gate",  32'(voice_gate), 32'(m_gate));
      check("trig",  32'(voice_trig), 32'(m_trig));
      check("steal", 32'(steal),      32'(m_steal));
      check("cnt",   32'(active_cnt), 32'($countones(m_gate)));
      check("notes", 32'(voice_note), 32'(en));
      check("vels",  32'(voice_vel),  32'(ev));
   endtask

   // Drive on the falling edge, sample 1 ns after the rising edge.
   task automatic cycle(input logic r, input logic c, input logic on,
                        input logic off, input logic [6:0] num, input logic [6:0] vel);
      @(negedge clk);
      rst = r; ce = c; note_on = on; note_off = off; note_num = num; note_vel = vel;
      @(posedge clk);
      model_step(r, c, on, off, num, vel);
      #1;
      compare_model();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic       ce, on, off;
      logic [6:0] num, vel;
      logic [3:0] gate, trig;
      logic       stl;
      logic [2:0] cnt;
      int         vi;
      logic [6:0] n, v;
   } vec_t;

   vec_t vecs [12];

   initial begin
      rst = 1'b1; ce = 1'b0; note_on = 1'b0; note_off = 1'b0;
      note_num = '0; note_vel = '0;

      //          ce   on   off  num    vel    gate     trig     stl  cnt  vi n      v
      vecs[0]  = '{1'b1,1'b1,1'b0,7'd60, 7'd100,4'b0001,4'b0001,1'b0,3'd1,0,7'd60, 7'd100};
      vecs[1]  = '{1'b1,1'b1,1'b0,7'd62, 7'd10, 4'b0011,4'b0010,1'b0,3'd2,1,7'd62, 7'd10};
      vecs[2]  = '{1'b1,1'b1,1'b0,7'd64, 7'd11, 4'b0111,4'b0100,1'b0,3'd3,2,7'd64, 7'd11};
      vecs[3]  = '{1'b1,1'b1,1'b0,7'd67, 7'd12, 4'b1111,4'b1000,1'b0,3'd4,3,7'd67, 7'd12};
      vecs[4]  = '{1'b1,1'b1,1'b0,7'd69, 7'd13, 4'b1111,4'b0001,1'b1,3'd4,0,7'd69, 7'd13};
      vecs[5]  = '{1'b1,1'b0,1'b0,7'd0,  7'd0,  4'b1111,4'b0000,1'b0,3'd4,0,7'd69, 7'd13};
      vecs[6]  = '{1'b1,1'b1,1'b1,7'd62, 7'd0,  4'b1101,4'b0000,1'b0,3'd3,1,7'd62, 7'd10};
      vecs[7]  = '{1'b1,1'b0,1'b1,7'd50, 7'd0,  4'b1101,4'b0000,1'b0,3'd3,1,7'd62, 7'd10};
      vecs[8]  = '{1'b1,1'b1,1'b0,7'd69, 7'd20, 4'b1101,4'b0001,1'b0,3'd3,0,7'd69, 7'd20};
      vecs[9]  = '{1'b1,1'b0,1'b0,7'd0,  7'd0,  4'b1101,4'b0000,1'b0,3'd3,2,7'd64, 7'd11};
      vecs[10] = '{1'b0,1'b1,1'b0,7'd70, 7'd30, 4'b1101,4'b0000,1'b0,3'd3,1,7'd62, 7'd10};
      vecs[11] = '{1'b1,1'b1,1'b0,7'd70, 7'd30, 4'b1111,4'b0010,1'b0,3'd4,1,7'd70, 7'd30};

      cycle(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
      check("rst_gate", 32'(voice_gate), 32'd0);
      check("rst_cnt",  32'(active_cnt), 32'd0);

      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, vecs[i].ce, vecs[i].on, vecs[i].off, vecs[i].num, vecs[i].vel);
         check($sformatf("tbl%0d_gate", i),  32'(voice_gate), 32'(vecs[i].gate));
         check($sformatf("tbl%0d_trig", i),  32'(voice_trig), 32'(vecs[i].trig));
         check($sformatf("tbl%0d_steal", i), 32'(steal),      32'(vecs[i].stl));
         check($sformatf("tbl%0d_cnt", i),   32'(active_cnt), 32'(vecs[i].cnt));
         check($sformatf("tbl%0d_note", i),  32'(voice_note[7*vecs[i].vi +: 7]), 32'(vecs[i].n));
         check($sformatf("tbl%0d_vel", i),   32'(voice_vel[7*vecs[i].vi +: 7]),  32'(vecs[i].v));
      end

      // Pulses must drop on a ce=0 cycle.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
      for (int v = 60; v < 64; v++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'(v), 7'd5);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 7'd64, 7'd5);
      check("ce0_trig",  32'(voice_trig), 32'd0);
      check("ce0_steal", 32'(steal),      32'd0);

      // Reset collides with an ON while all voices are gated.
      check("full_before_rst", 32'(voice_gate), 32'hf);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 7'd80, 7'd9);
      check("rst_ev_gate",  32'(voice_gate), 32'd0);
      check("rst_ev_trig",  32'(voice_trig), 32'd0);
      check("rst_ev_notes", 32'(voice_note), 32'd0);
      check("rst_ev_cnt",   32'(active_cnt), 32'd0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd81, 7'd9);
      check("post_rst_trig", 32'(voice_trig), 32'h1);
      check("post_rst_note", 32'(voice_note[6:0]), 32'd81);
      // Fill the rest; with reset ages voice0 becomes the steal victim.
      for (int v = 82; v < 85; v++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'(v), 7'd9);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 7'd85, 7'd9);
      check("age_steal_trig", 32'(voice_trig), 32'h1);
      check("age_steal",      32'(steal),      32'h1);

      // Random events over a narrow note range to provoke matches and steals.
      for (int i = 0; i < 2000; i++) begin
         logic r, c, on, off;
         logic [6:0] num, vel;
         r   = ($urandom_range(0, 99) == 0);
         c   = ($urandom_range(0, 3) != 0);
         on  = ($urandom_range(0, 2) != 0);
         off = ($urandom_range(0, 3) == 0);
         num = 7'(60 + $urandom_range(0, 6));
         vel = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
         if (on && vel == 7'd0) off = 1'b1;
         cycle(r, c, on, off, num, vel);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
